// File: rtl/fetch_sequencer_if.sv
// Fetch-side bus between the core control unit, the program ROM and the fetch sequencer.
// The master side drives control and the ROM word; the slave side (sequencer) drives fetch state.
interface fetch_sequencer_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  stall;
    logic                  redirect_valid;
    logic [DATA_WIDTH-1:0] redirect_addr;
    logic                  halt_req;
    logic                  resume;
    logic [DATA_WIDTH-1:0] Instruction;
    logic [DATA_WIDTH-1:0] Address;
    logic [DATA_WIDTH-1:0] instr_q;
    logic [DATA_WIDTH-1:0] pc_q;
    logic [DATA_WIDTH-1:0] pc_plus4_q;
    logic                  valid_q;
    logic                  halted;
    logic                  fault;
    logic [DATA_WIDTH-1:0] fault_pc;

    modport master (
        output stall, redirect_valid, redirect_addr, halt_req, resume, Instruction,
        input  Address, instr_q, pc_q, pc_plus4_q, valid_q, halted, fault, fault_pc
    );

    modport slave (
        input  stall, redirect_valid, redirect_addr, halt_req, resume, Instruction,
        output Address, instr_q, pc_q, pc_plus4_q, valid_q, halted, fault, fault_pc
    );
endinterface

// File: rtl/fetch_sequencer.sv
// Program counter and IF/ID fetch stage: zero-latency ROM capture with stall,
// redirect, halt/resume and sticky out-of-range fault handling.
module fetch_sequencer #(
    parameter int                        DATA_WIDTH   = 32,
    parameter logic [DATA_WIDTH-1:0]     TEXT_BASE    = 32'h0040_0000,
    parameter int                        MEMORY_DEPTH = 32
) (
    input  logic               clk,
    input  logic               reset,
    fetch_sequencer_if.slave   bus
);
    typedef enum logic [1:0] {RUN, HALT, FAULT} state_t;

    localparam logic [DATA_WIDTH-1:0] TEXT_SIZE = DATA_WIDTH'(MEMORY_DEPTH * 4);
    localparam logic [DATA_WIDTH-1:0] WORD      = DATA_WIDTH'(4);

    state_t                state;
    logic [DATA_WIDTH-1:0] pc;
    logic [DATA_WIDTH-1:0] pc_next_seq;
    logic                  redirect_ok;
    logic                  seq_ok;

    // Word aligned, at or above the base, and inside the ROM window.
    function automatic logic in_range(input logic [DATA_WIDTH-1:0] addr);
        return (addr[1:0] == 2'b00) && (addr >= TEXT_BASE) && ((addr - TEXT_BASE) < TEXT_SIZE);
    endfunction

    assign bus.Address  = pc - TEXT_BASE;
    assign pc_next_seq  = pc + WORD;
    assign redirect_ok  = in_range(bus.redirect_addr);
    assign seq_ok       = in_range(pc_next_seq);

    // NOTE: all state updates use non-blocking assignments so every register
    // samples pre-edge values; the reset branch is asynchronous.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= RUN;
            pc             <= TEXT_BASE;
            bus.instr_q    <= '0;
            bus.pc_q       <= '0;
            bus.pc_plus4_q <= '0;
            bus.valid_q    <= 1'b0;
            bus.halted     <= 1'b0;
            bus.fault      <= 1'b0;
            bus.fault_pc   <= '0;
        end else begin
            case (state)
                RUN: begin
                    if (bus.redirect_valid) begin
                        bus.valid_q <= 1'b0;
                        if (redirect_ok) begin
                            pc <= bus.redirect_addr;
                        end else begin
                            state        <= FAULT;
                            bus.fault    <= 1'b1;
                            bus.fault_pc <= bus.redirect_addr;
                        end
                    end else if (bus.halt_req) begin
                        state       <= HALT;
                        bus.halted  <= 1'b1;
                        bus.valid_q <= 1'b0;
                    end else if (!bus.stall) begin
                        bus.instr_q    <= bus.Instruction;
                        bus.pc_q       <= pc;
                        bus.pc_plus4_q <= pc_next_seq;
                        bus.valid_q    <= 1'b1;
                        // The last word is still delivered; only the step past it faults.
                        if (seq_ok) begin
                            pc <= pc_next_seq;
                        end else begin
                            state        <= FAULT;
                            bus.fault    <= 1'b1;
                            bus.fault_pc <= pc_next_seq;
                        end
                    end
                end
                HALT: begin
                    bus.valid_q <= 1'b0;
                    if (bus.redirect_valid && !redirect_ok) begin
                        state        <= FAULT;
                        bus.halted   <= 1'b0;
                        bus.fault    <= 1'b1;
                        bus.fault_pc <= bus.redirect_addr;
                    end else begin
                        if (bus.redirect_valid) begin
                            pc <= bus.redirect_addr;
                        end
                        if (bus.resume) begin
                            state      <= RUN;
                            bus.halted <= 1'b0;
                        end
                    end
                end
                default: begin
                    bus.valid_q <= 1'b0;
                end
            endcase
        end
    end
endmodule
